// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade of the down-counter; load wins over decrement.
module bcd_down_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_in_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  output logic [3:0] digit_o,
  output logic       borrow_out_o
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (ld_i)
      digit_d = bcd_sat(ld_val_i);
    else if (dec_in_i)
      digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit_o      = digit_q;
  assign borrow_out_o = dec_in_i & (digit_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with load/start/pause and a terminal-count pulse.
// Optional auto-reload on expiry when BCD_TIMER_AUTO_RELOAD_EN is defined.
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  input  logic                  start_i,
  input  logic                  pause_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  busy_o,
  output logic                  zero_o,
  output logic                  done_o
);

  localparam int CW = 4 * DIGITS;

  state_t state_q, state_d;
  logic   done_q, done_d;

  logic [DIGITS-1:0][3:0] digits;
  logic [DIGITS-1:0][3:0] load_sat;
  logic [DIGITS:0]        borrow;
  logic [CW-1:0]          count, ld_src;
  logic                   run_tick, expire, reload_fire, dec, ld_any, count_one;

  assign count     = digits;
  assign count_one = (count == CW'(1));
  assign run_tick  = (state_q == RUN) & en_i & ~pause_i & ~load_i;
  assign expire    = run_tick & count_one;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [CW-1:0] reload_q;

  always_ff @(posedge clk) begin
    if (rst)         reload_q <= '0;
    else if (load_i) reload_q <= load_sat;
  end

  assign reload_fire = expire & (reload_q != '0);
  assign ld_src      = load_i ? CW'(load_sat) : (reload_fire ? reload_q : '0);
`else
  assign reload_fire = 1'b0;
  assign ld_src      = load_i ? CW'(load_sat) : '0;
`endif

  // The top borrow only fires on a decrement from zero; clamp instead of wrapping.
  assign dec       = run_tick & ~reload_fire;
  assign ld_any    = load_i | reload_fire | borrow[DIGITS];
  assign borrow[0] = dec;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign load_sat[i] = bcd_sat(load_val_i[4*i +: 4]);

    bcd_down_digit u_digit (
      .clk          (clk),
      .rst          (rst),
      .dec_in_i     (borrow[i]),
      .ld_i         (ld_any),
      .ld_val_i     (ld_src[4*i +: 4]),
      .digit_o      (digits[i]),
      .borrow_out_o (borrow[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (load_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i && !zero_o) state_d = RUN;
        RUN: begin
          if (pause_i) begin
            state_d = PAUSED;
          end else if (expire) begin
            done_d = 1'b1;
            if (!reload_fire) state_d = EXPIRED;
          end
        end
        PAUSED:  if (start_i) state_d = RUN;
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count;
  assign busy_o  = (state_q == RUN);
  assign zero_o  = (count == '0);
  assign done_o  = done_q;

endmodule
